// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: default widths,
// grant encoding and the port index used in the one-hot grant vector.
package dmem_arb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;

    // Identity of the requester that won the most recent transfer.
    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_DMA  = 1'b1
    } gnt_e;

    // Bit positions inside the one-hot grant / eligibility vectors.
    localparam int IDX_CORE = 0;
    localparam int IDX_DMA  = 1;

endpackage

// File: rtl/dmem_arbiter_rsp_slot.sv
// One-entry response holding register. A fill loads new data and sets valid;
// a drain clears it unless a fill lands in the same cycle.
module dmem_arbiter_rsp_slot
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_fill,
    input  logic [DATA_WIDTH-1:0] i_fill_data,
    input  logic                  i_drain,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // Hold the response until consumed; a same-cycle refill wins over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_data  <= i_fill_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone eligible port wins outright, and on a
// tie the port that did not win last time gets the grant.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  gnt_e       last_grant,
    output logic [1:0] grant,
    output logic       valid
);

    // Pick at most one winner; core takes the tie when dma won last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the ifs leaves it unassigned and infers a latch.
        grant = 2'b00;
        if (eligible[IDX_CORE] && (!eligible[IDX_DMA] || last_grant == GNT_DMA)) begin
            grant[IDX_CORE] = 1'b1;
        end else if (eligible[IDX_DMA]) begin
            grant[IDX_DMA] = 1'b1;
        end
    end

    assign valid = |eligible;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core port and a dma port onto one single-ported data memory
// with combinational read data. One transfer per cycle, round-robin on ties,
// and a one-deep response slot per port that answers the cycle after transfer.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_we,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_valid,
    input  logic                  core_rsp_ready,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,

    input  logic                  dma_req_valid,
    output logic                  dma_req_ready,
    input  logic                  dma_req_we,
    input  logic [ADDR_WIDTH-1:0] dma_req_addr,
    input  logic [DATA_WIDTH-1:0] dma_req_wdata,
    output logic                  dma_rsp_valid,
    input  logic                  dma_rsp_ready,
    output logic [DATA_WIDTH-1:0] dma_rsp_rdata,

    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    gnt_e                  r_last_grant;
    logic [1:0]            w_eligible;
    logic [1:0]            w_grant;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_core_fill_data;
    logic [DATA_WIDTH-1:0] w_dma_fill_data;

    // A port may transfer when its slot is free or being emptied this cycle.
    // Gating with rst_n keeps every grant-derived output low during reset.
    assign w_eligible[IDX_CORE] = rst_n && core_req_valid && (!core_rsp_valid || core_rsp_ready);
    assign w_eligible[IDX_DMA]  = rst_n && dma_req_valid  && (!dma_rsp_valid  || dma_rsp_ready);

    rr_arb2 u_rr_arb2 (
        .eligible   (w_eligible),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .valid      (w_xfer)
    );

    assign core_req_ready = w_grant[IDX_CORE];
    assign dma_req_ready  = w_grant[IDX_DMA];

    // Steer the winner onto the memory port; drive zeros when idle.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (w_grant[IDX_CORE]) begin
            mem_wr_en   = core_req_we;
            mem_addr    = core_req_addr;
            mem_wr_data = core_req_wdata;
        end else if (w_grant[IDX_DMA]) begin
            mem_wr_en   = dma_req_we;
            mem_addr    = dma_req_addr;
            mem_wr_data = dma_req_wdata;
        end
    end

    // Remember who won the last transfer; idle cycles leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_DMA;
        end else if (w_xfer) begin
            r_last_grant <= w_grant[IDX_DMA] ? GNT_DMA : GNT_CORE;
        end
    end

    // Loads capture memory read data; stores acknowledge with zero.
    assign w_core_fill_data = core_req_we ? '0 : mem_rd_data;
    assign w_dma_fill_data  = dma_req_we  ? '0 : mem_rd_data;

    dmem_arbiter_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_core_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fill      (w_grant[IDX_CORE]),
        .i_fill_data (w_core_fill_data),
        .i_drain     (core_rsp_ready),
        .o_valid     (core_rsp_valid),
        .o_data      (core_rsp_rdata)
    );

    dmem_arbiter_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_dma_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fill      (w_grant[IDX_DMA]),
        .i_fill_data (w_dma_fill_data),
        .i_drain     (dma_rsp_ready),
        .o_valid     (dma_rsp_valid),
        .o_data      (dma_rsp_rdata)
    );

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 For each requester X in {core, dma}, the block SHALL have these ports:
- X_req_valid, input, 1: request present.
- X_req_ready, output, 1: request accepted this cycle.
- X_req_we, input, 1: 1 = store, 0 = load.
- X_req_addr, input, ADDR_WIDTH: byte address.
- X_req_wdata, input, DATA_WIDTH: store data.
- X_rsp_valid, output, 1: response held.
- X_rsp_ready, input, 1: response consumed.
- X_rsp_rdata, output, DATA_WIDTH: load data, 0 for store acks.
REQ-006 Memory-side ports SHALL be:
- mem_wr_en, output, 1.
- mem_addr, output, ADDR_WIDTH.
- mem_wr_data, output, DATA_WIDTH.
- mem_rd_data, input, DATA_WIDTH: combinational read data from the word-addressed data memory.

Function
REQ-007 At most one request SHALL be granted per cycle.
REQ-008 Handshake: a transfer occurs when X_req_valid && X_req_ready.
- Requester holds valid, we, addr and wdata stable until the transfer.
- X_req_ready SHALL be combinational from valid, slot state and arbiter state.
REQ-009 Port X is eligible when X_req_valid = 1 and its response slot is empty, or is draining this cycle (X_rsp_valid && X_rsp_ready).
REQ-010 Arbitration SHALL be round-robin, two-way, via register last_grant:
- One port eligible: that port wins.
- Both eligible: the port not equal to last_grant wins.
- last_grant updates only on a transfer.
REQ-011 Memory drive in the transfer cycle:
- mem_addr = winner addr.
- mem_wr_data = winner wdata.
- mem_wr_en = winner we.
- No transfer: mem_wr_en = 0, mem_addr = 0, mem_wr_data = 0.
REQ-012 Stores SHALL commit at the posedge ending the transfer cycle.
REQ-013 On a load transfer, mem_rd_data SHALL be captured into the winner's response slot at the same posedge.
REQ-014 Latency: X_rsp_valid SHALL rise the cycle after the transfer, for loads and stores (store ack, rdata = 0).
REQ-015 A response slot SHALL hold rsp_valid and rdata stable until X_rsp_ready = 1.
- Slot clears at that posedge unless refilled by a same-cycle transfer.
- Refill makes rsp_valid stay 1 with the new data.
REQ-016 Address low bits [1:0] SHALL pass through unchanged; no alignment checking.
REQ-017 Simultaneous core load and dma store to the same word: the grant winner executes first; the loser is serviced a later cycle and sees memory state after the winner.
REQ-018 Response slots SHALL be independent: a stalled core response does not block dma grants.

Reset
REQ-019 While rst_n = 0, the block SHALL hold:
- both rsp_valid = 0, both rsp_rdata = 0.
- both req_ready = 0.
- mem_wr_en = 0, mem_addr = 0, mem_wr_data = 0.
- last_grant = dma, so core wins the first tie.
REQ-020 Reset mid-operation SHALL drop pending responses, with no memory write in the reset cycle.
REQ-021 Reset deassertion SHALL be synchronised externally; operation starts on the first posedge with rst_n = 1.

Structure
REQ-022 Shared package dmem_arb_pkg SHALL hold the DATA_WIDTH/ADDR_WIDTH defaults and the grant encoding enum GNT_CORE/GNT_DMA.
REQ-023 The round-robin decision SHALL be sub-module rr_arb2: inputs eligible[1:0], last_grant; outputs grant onehot, valid.
REQ-024 The response slot SHALL be one parameterised register, instantiated twice.

Verification
REQ-025 Core store 0xDEADBEEF to 0x10, then core load 0x10 -> rsp_valid one cycle after each transfer; load rdata = 0xDEADBEEF; store ack rdata = 0.
REQ-026 Both ports valid continuously for 6 cycles, rsp_ready = 1 -> grants alternate core, dma, core, dma, core, dma.
REQ-027 Core load, core_rsp_ready = 0 for 3 cycles, core still valid -> core_req_ready = 0 for those cycles; dma grants continue; core rdata stable.
REQ-028 Same cycle: core load 0x20 and dma store 0x55 to 0x20, last_grant = dma -> core gets the old value; next cycle the dma store commits; a subsequent load returns 0x55.
REQ-029 Assert rst_n = 0 while core_rsp_valid = 1 -> rsp_valid drops immediately; no mem_wr_en; after release the core wins the first tie.
